bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
// N-channel read arbiter that shares one synchronous memory read port among
// NUM_CHANNELS requesters. Each channel uses a req/rdy four-phase handshake.
// Winners are chosen round-robin or by fixed priority. Memory read latency is
// configurable, and a request withdrawn mid-read is dropped cleanly.
// Sits between pixel/frame-buffer readers and a shared block RAM.
// PARAMETERS
// NUM_CHANNELS  4  requesters; must be >= 2
// ADDRESS_WIDTH 8  memory address width
// DATA_WIDTH    8  memory data width
// READ_LATENCY  1  memory cycles from address sampled to data valid; 1..4
// ROUND_ROBIN   1  1 = rotating priority; 0 = fixed priority, ch0 highest
// PORTS
// clk           in  1      clock, rising edge
// rst_n         in  1      asynchronous reset, active low
// data_req      in  N      per-channel request; held high until rdy is seen
// data_addr     in  N*AW   ch i address in [i*AW +: AW]; stable while req high
// data          out N*DW   ch i read data in [i*DW +: DW]
// data_rdy      out N      per-channel data valid
// mem_data_addr out AW     registered memory address
// mem_rd_en     out 1      one-cycle read strobe
// mem_data      in  DW     memory read data
// busy          out 1      read in flight (state != IDLE)
// BEHAVIOUR
// - Reset (async, rst_n low): all outputs 0, state IDLE, cnt 0, rr_ptr=N-1
//   (ch0 wins first). An in-flight read is aborted; late mem_data is ignored.
// - Eligible[i] = data_req[i] & ~data_rdy[i].
// - data_rdy[i] clears on the first edge that samples data_req[i] low.
//   It is never set while data_req[i] is low.
// - FSM IDLE:
//   - If any channel is eligible, pick winner g:
//     - ROUND_ROBIN=1: first eligible index scanning rr_ptr+1 .. wrapping
//       through N-1 and 0; rr_ptr <= g.
//     - ROUND_ROBIN=0: lowest eligible index; rr_ptr unused.
//   - Same edge: latch g; mem_data_addr <= data_addr[g]; mem_rd_en <= 1;
//     cnt <= 0; go to READ.
// - FSM READ:
//   - mem_rd_en drops after one cycle.
//   - cnt increments each edge.
//   - On the edge where cnt == READ_LATENCY, capture mem_data and go to IDLE.
//     That is edge E0+READ_LATENCY+1, where E0 is the grant edge.
//   - At capture, if data_req[g] is still high:
//     data[g] <= mem_data and data_rdy[g] <= 1.
//     Otherwise the data is discarded and data[g] and data_rdy[g] are unchanged.
// - Latency: req sampled at grant edge k -> rdy visible after edge k+READ_LATENCY+1.
//   Throughput is one read per READ_LATENCY+2 cycles.
// - data_addr changes after the grant are ignored.
// - mem_data_addr holds its last value when idle. Other channels' data
//   registers hold their values.
// - Simultaneous requests: exactly one grant per IDLE cycle. Losers stay
//   eligible; no request is lost. Round-robin guarantees each eligible
//   channel is served within N grants.
// - Index width is max(1, $clog2(N)). rr_ptr wraps from N-1 to 0.
// TESTING
// 1 rst_n low mid-run -> all outputs 0 with no clock edge; rst_n high ->
//   first grant goes to ch0 when all channels request.
// 2 N=4, L=1, mem returns ~addr. ch2 req with addr 0x5A, sampled at edge k ->
//   mem_rd_en pulse after edge k; data[2]=0xA5 and rdy[2]=1 after edge k+2.
//   Drop req -> rdy[2]=0 next edge.
// 3 RR: all 4 request in the same cycle -> grant order 0,1,2,3, each after
//   L+2 cycles. After ch1 is served, ch0 and ch3 request -> ch3 first.
// 4 ROUND_ROBIN=0: ch0 and ch1 request together -> ch0 served first.
//   ch0 re-requests before ch1 is granted -> ch0 still wins.
// 5 L=3: ch1 drops req one cycle after its grant -> no rdy[1], data[1]
//   unchanged. busy low after 4 edges, then pending ch2 is served with correct data.
// 6 L=3: assert rst_n low two cycles after a grant -> outputs 0 immediately.
//   After release, the stale mem_data is never captured.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: shares one synchronous memory read port among NUM_CHANNELS
// requesters using a req/rdy four-phase handshake. The arbiter picks one
// winner per idle cycle, either round-robin or by fixed priority with ch0
// highest. It issues a one-cycle read strobe and captures the memory data
// READ_LATENCY cycles later. If the winning request has been withdrawn by
// then, the captured data is discarded.

module bus_arbiter_rr #(
    parameter int NUM_CHANNELS  = 4,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int READ_LATENCY  = 1,
    parameter int ROUND_ROBIN   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CHANNELS-1:0]              data_req,
    input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] data_addr,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    data,
    output logic [NUM_CHANNELS-1:0]              data_rdy,
    output logic [ADDRESS_WIDTH-1:0]             mem_data_addr,
    output logic                                 mem_rd_en,
    input  logic [DATA_WIDTH-1:0]                mem_data,
    output logic                                 busy
);

    // Channel index width; a single-bit index is kept even for tiny N.
    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    // The latency counter only has to reach READ_LATENCY (at most 4).
    localparam int CNT_W = 3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);
    localparam logic [CNT_W-1:0] LAT_CNT  = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_e                               state_q, state_d;
    logic [CNT_W-1:0]                     cnt_q, cnt_d;
    logic [IDX_W-1:0]                     grant_q, grant_d;
    logic [IDX_W-1:0]                     rr_ptr_q, rr_ptr_d;
    logic [ADDRESS_WIDTH-1:0]             mem_addr_q, mem_addr_d;
    logic                                 mem_rd_en_q, mem_rd_en_d;
    logic                                 busy_q, busy_d;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0]   data_q, data_d;
    logic [NUM_CHANNELS-1:0]              data_rdy_q, data_rdy_d;

    // ------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------
    logic [NUM_CHANNELS-1:0]              eligible_s;
    logic                                 win_found_s;
    logic [IDX_W-1:0]                     win_idx_s;
    logic [IDX_W-1:0]                     scan_idx_s;
    logic                                 capture_s;

    // Winner selection: a channel is eligible while it requests and has not yet been served.
    always_comb begin
        eligible_s  = data_req & ~data_rdy_q;
        win_found_s = 1'b0;
        win_idx_s   = '0;
        scan_idx_s  = '0;
        if (ROUND_ROBIN != 0) begin
            // Scan starts one past the last winner and wraps, so the first hit is the winner.
            for (int off = 1; off <= NUM_CHANNELS; off++) begin
                scan_idx_s  = IDX_W'((int'(rr_ptr_q) + off) % NUM_CHANNELS);
                win_idx_s   = (!win_found_s && eligible_s[scan_idx_s]) ? scan_idx_s : win_idx_s;
                win_found_s = win_found_s | eligible_s[scan_idx_s];
            end
        end else begin
            // Descending scan: the last hit, which is the lowest eligible index, wins.
            for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
                win_idx_s = eligible_s[i] ? IDX_W'(i) : win_idx_s;
            end
            win_found_s = |eligible_s;
        end
    end

    // Control FSM next state: grant in IDLE, count out the memory latency in READ.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        capture_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    grant_d     = win_idx_s;
                    rr_ptr_d    = (ROUND_ROBIN != 0) ? win_idx_s : rr_ptr_q;
                    mem_addr_d  = data_addr[int'(win_idx_s)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    mem_rd_en_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_READ;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_q == LAT_CNT) begin
                    capture_s = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                    state_d   = ST_READ;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Per-channel data/ready next state: ready drops with the request, capture only if still requested.
    always_comb begin
        data_d     = data_q;
        data_rdy_d = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            data_d[i*DATA_WIDTH +: DATA_WIDTH] =
                (capture_s && data_req[i] && (grant_q == IDX_W'(i))) ?
                mem_data : data_q[i*DATA_WIDTH +: DATA_WIDTH];
            data_rdy_d[i] = data_req[i] &
                            (data_rdy_q[i] | (capture_s & (grant_q == IDX_W'(i))));
        end
    end

    // Control registers; reset aborts any read in flight and points rr_ptr so ch0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= LAST_IDX;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            busy_q      <= busy_d;
        end
    end

    // Channel data and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            data_rdy_q <= '0;
        end else begin
            data_q     <= data_d;
            data_rdy_q <= data_rdy_d;
        end
    end

    assign data          = data_q;
    assign data_rdy      = data_rdy_q;
    assign mem_data_addr = mem_addr_q;
    assign mem_rd_en     = mem_rd_en_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr. Three instances share the clock and reset:
// instance 0 is round-robin with L=1, instance 1 is fixed priority with L=1,
// and instance 2 is round-robin with L=3. Each instance has a pipelined
// memory that returns ~addr, plus a transaction-level reference model that
// is compared against the DUT on every falling edge. Directed scenarios are
// followed by a randomized phase.

module tb_bus_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req   [NI];
    logic [N*AW-1:0] addr  [NI];
    logic [N*DW-1:0] dout  [NI];
    logic [N-1:0]    rdy   [NI];
    logic [AW-1:0]   maddr [NI];
    logic            rden  [NI];
    logic [DW-1:0]   mdata [NI];
    logic            bsy   [NI];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit rnd_mode [NI];

    function automatic int lat_of(int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic bit rr_of(int k);
        return (k != 1);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    generate
        for (genvar k = 0; k < NI; k++) begin : g_inst
            localparam int LK = (k == 2) ? 3 : 1;
            logic [DW-1:0] pipe [4];

            bus_arbiter_rr #(
                .NUM_CHANNELS (N),
                .ADDRESS_WIDTH(AW),
                .DATA_WIDTH   (DW),
                .READ_LATENCY (LK),
                .ROUND_ROBIN  ((k == 1) ? 0 : 1)
            ) u_dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .data_req     (req[k]),
                .data_addr    (addr[k]),
                .data         (dout[k]),
                .data_rdy     (rdy[k]),
                .mem_data_addr(maddr[k]),
                .mem_rd_en    (rden[k]),
                .mem_data     (mdata[k]),
                .busy         (bsy[k])
            );

            // Memory: returns ~addr LK cycles after the strobe; garbage otherwise.
            always @(posedge clk) begin
                pipe[0] <= rden[k] ? ~maddr[k] : DW'($urandom);
                for (int s = 1; s < 4; s++) pipe[s] <= pipe[s-1];
            end
            assign mdata[k] = pipe[LK-1];
        end
    endgenerate

    // ---------------- reference model (transaction level) ----------------
    bit              m_busy [NI];
    int              m_g    [NI];
    int              m_left [NI];
    logic [AW-1:0]   m_addr [NI];
    bit              m_rden [NI];
    logic [N-1:0]    m_rdy  [NI];
    logic [N*DW-1:0] m_data [NI];
    int              m_ptr  [NI];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < NI; k++) begin
                if (!rst_n) begin
                    m_busy[k] = 1'b0; m_g[k] = 0; m_left[k] = 0; m_addr[k] = '0;
                    m_rden[k] = 1'b0; m_rdy[k] = '0; m_data[k] = '0; m_ptr[k] = N - 1;
                end else begin
                    logic [N-1:0] elig;
                    int w;
                    elig = req[k] & ~m_rdy[k];
                    m_rdy[k] = m_rdy[k] & req[k];
                    m_rden[k] = 1'b0;
                    if (m_busy[k]) begin
                        m_left[k]--;
                        if (m_left[k] == 0) begin
                            m_busy[k] = 1'b0;
                            if (req[k][m_g[k]]) begin
                                m_data[k][m_g[k]*DW +: DW] = ~m_addr[k];
                                m_rdy[k][m_g[k]] = 1'b1;
                            end
                        end
                    end else if (elig != '0) begin
                        w = -1;
                        for (int j = 0; j < N; j++) begin
                            int c;
                            c = rr_of(k) ? (m_ptr[k] + 1 + j) % N : j;
                            if (w < 0 && elig[c]) w = c;
                        end
                        m_g[k] = w;
                        if (rr_of(k)) m_ptr[k] = w;
                        m_addr[k] = addr[k][w*AW +: AW];
                        m_rden[k] = 1'b1;
                        m_busy[k] = 1'b1;
                        m_left[k] = lat_of(k) + 1;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison of every instance against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                check_eq($sformatf("i%0d data", k), dout[k], m_data[k]);
                check_eq($sformatf("i%0d rdy", k), rdy[k], m_rdy[k]);
                check_eq($sformatf("i%0d busy", k), bsy[k], m_busy[k]);
                check_eq($sformatf("i%0d rd_en", k), rden[k], m_rden[k]);
                check_eq($sformatf("i%0d mem_addr", k), maddr[k], m_addr[k]);
            end
        end
    end

    // Requester behaviour: random four-phase traffic, or auto-release after rdy.
    initial forever begin
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < N; i++) begin
                if (rnd_mode[k]) begin
                    if (!req[k][i]) begin
                        if ($urandom_range(0, 2) == 0) begin
                            addr[k][i*AW +: AW] = AW'($urandom);
                            req[k][i] = 1'b1;
                        end
                    end else if (rdy[k][i]) begin
                        if ($urandom_range(0, 1) == 0) req[k][i] = 1'b0;
                    end else if ($urandom_range(0, 39) == 0) begin
                        req[k][i] = 1'b0;
                    end
                end else if (req[k][i] && rdy[k][i]) begin
                    req[k][i] = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int i, input logic [AW-1:0] a);
        addr[k][i*AW +: AW] = a;
        req[k][i] = 1'b1;
    endtask

    // Waits (bounded) for a read strobe on instance k and returns its address.
    task automatic wait_grant(input int k, output logic [AW-1:0] a);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            step(1);
            seen = rden[k];
        end
        check_eq($sformatf("i%0d grant seen", k), seen, 1'b1);
        a = maddr[k];
    endtask

    logic [AW-1:0] ga;
    int prev_cyc;

    initial begin
        for (int k = 0; k < NI; k++) begin
            req[k] = '0; addr[k] = '0; rnd_mode[k] = 1'b0;
        end
        step(3);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step(2);

        // All four request together: grant order 0,1,2,3 spaced L+2 cycles.
        for (int i = 0; i < N; i++) set_req(0, i, AW'(8'h10 + i));
        prev_cyc = 0;
        for (int j = 0; j < N; j++) begin
            wait_grant(0, ga);
            check_eq($sformatf("rr order %0d", j), ga, AW'(8'h10 + j));
            if (j > 0) check_eq("rr spacing", cyc - prev_cyc, 3);
            prev_cyc = cyc;
        end
        step(4);
        // Serve ch1 alone, then ch0 and ch3 together: ch3 must come first.
        set_req(0, 1, 8'h21);
        wait_grant(0, ga);
        check_eq("ch1 alone", ga, 8'h21);
        step(5);
        set_req(0, 0, 8'h30);
        set_req(0, 3, 8'h33);
        wait_grant(0, ga);
        check_eq("rr after ch1", ga, 8'h33);
        wait_grant(0, ga);
        check_eq("rr then ch0", ga, 8'h30);
        step(6);

        // Single read, latency check with L=1.
        set_req(0, 2, 8'h5A);
        step(1);
        check_eq("t2 rd_en", rden[0], 1'b1);
        check_eq("t2 addr", maddr[0], 8'h5A);
        step(1);
        check_eq("t2 rd_en drop", rden[0], 1'b0);
        check_eq("t2 rdy early", rdy[0][2], 1'b0);
        step(1);
        check_eq("t2 data", dout[0][2*DW +: DW], 8'hA5);
        check_eq("t2 rdy", rdy[0][2], 1'b1);
        step(1);
        check_eq("t2 rdy clear", rdy[0][2], 1'b0);

        // Fixed priority: ch0 re-requests while ch1 is served and still beats ch2.
        set_req(1, 0, 8'h40);
        set_req(1, 1, 8'h41);
        set_req(1, 2, 8'h42);
        wait_grant(1, ga);
        check_eq("fp first", ga, 8'h40);
        wait_grant(1, ga);
        check_eq("fp second", ga, 8'h41);
        set_req(1, 0, 8'h44);
        wait_grant(1, ga);
        check_eq("fp ch0 again", ga, 8'h44);
        wait_grant(1, ga);
        check_eq("fp ch2 last", ga, 8'h42);
        step(6);

        // L=3: ch1 withdraws one cycle after grant; pending ch2 then served.
        set_req(2, 1, 8'h51);
        set_req(2, 2, 8'h62);
        wait_grant(2, ga);
        check_eq("t5 grant ch1", ga, 8'h51);
        step(1);
        req[2][1] = 1'b0;
        step(3);
        check_eq("t5 busy low", bsy[2], 1'b0);
        check_eq("t5 no rdy1", rdy[2][1], 1'b0);
        check_eq("t5 data1 kept", dout[2][1*DW +: DW], 8'h00);
        wait_grant(2, ga);
        check_eq("t5 grant ch2", ga, 8'h62);
        step(4);
        check_eq("t5 data2", dout[2][2*DW +: DW], 8'h9D);
        check_eq("t5 rdy2", rdy[2][2], 1'b1);
        step(4);

        // L=3: reset two cycles after a grant; stale data must never land.
        set_req(2, 3, 8'h77);
        wait_grant(2, ga);
        check_eq("t6 grant ch3", ga, 8'h77);
        step(2);
        rst_n = 1'b0;
        req[2][3] = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check_eq("rst data", dout[k], '0);
            check_eq("rst rdy", rdy[k], '0);
            check_eq("rst addr", maddr[k], '0);
            check_eq("rst rd_en", rden[k], 1'b0);
            check_eq("rst busy", bsy[k], 1'b0);
        end
        step(2);
        rst_n = 1'b1;
        set_req(2, 0, 8'h0F);
        wait_grant(2, ga);
        check_eq("t6 post-rst grant", ga, 8'h0F);
        step(4);
        check_eq("t6 data0", dout[2][0*DW +: DW], 8'hF0);
        check_eq("t6 data3 zero", dout[2][3*DW +: DW], 8'h00);
        check_eq("t6 rdy3 zero", rdy[2][3], 1'b0);
        step(4);

        // Randomized traffic on all instances against the model.
        for (int k = 0; k < NI; k++) rnd_mode[k] = 1'b1;
        step(3000);
        for (int k = 0; k < NI; k++) rnd_mode[k] = 1'b0;
        step(20);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
